// File: rtl/cms_ctrl_pkg.sv
// Shared widths, command record and sequencer state encoding for the CMS control path.
package cms_ctrl_pkg;

  localparam int unsigned CTRL_ADDR_WIDTH = 8;
  localparam int unsigned CTRL_DATA_WIDTH = 64;

  typedef struct packed {
    logic [CTRL_ADDR_WIDTH-1:0] addr;
    logic [CTRL_DATA_WIDTH-1:0] wdata;
  } cms_ctrl_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } cms_seq_state_e;

endpackage

// File: rtl/cms_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally, level is registered.
module cms_cmd_fifo
  import cms_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cms_ctrl_cmd_t            push_cmd,
  input  logic                     pop,
  input  logic                     flush,
  output cms_ctrl_cmd_t            head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  cms_ctrl_cmd_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (level != FULL_LVL);
  assign do_pop  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= push_cmd;
  end

  // Flush wins over a concurrent push; a concurrent pop has already sampled head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cms_ctrl_sequencer.sv
// Queues CMS control writes and replays them as setup/strobe/gap framed writes.
// Optional drop counter enabled by macro CMS_CTRL_SEQ_DROP_CNT_EN.
module cms_ctrl_sequencer
  import cms_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES    = 1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] cmd_wdata,
  input  logic                       flush,
  input  logic                       run,
  output logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  output logic                       ctrl_write_enable,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]       writes_issued
`ifdef CMS_CTRL_SEQ_DROP_CNT_EN
  ,
  input  logic                       drop_count_clr,
  output logic [15:0]                drop_count
`endif
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  cms_seq_state_e state;
  cms_seq_state_e state_nxt;
  cms_ctrl_cmd_t  head;
  cms_ctrl_cmd_t  push_cmd;
  logic [31:0]    cyc_cnt;
  logic           push;
  logic           pop;
  logic           last_strobe;
  logic           last_gap;

  assign cmd_ready   = (fifo_level < LW'(DEPTH));
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == IDLE) && run && (fifo_level != '0);
  assign push_cmd    = '{addr: cmd_addr, wdata: cmd_wdata};
  assign last_strobe = (state == STROBE) && (cyc_cnt == 32'(STROBE_CYCLES - 1));
  assign last_gap    = (state == GAP) && (cyc_cnt == 32'(GAP_CYCLES - 1));

  cms_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .level    (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (last_strobe) state_nxt = GAP;
      GAP:     if (last_gap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctrl_write_enable = (state == STROBE);
    busy              = (state != IDLE) || (fifo_level != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt       <= '0;
      ctrl_addr     <= '0;
      ctrl_wdata    <= '0;
      writes_issued <= '0;
    end else begin
      if (state != state_nxt)
        cyc_cnt <= '0;
      else if (state == STROBE || state == GAP)
        cyc_cnt <= cyc_cnt + 32'd1;
      if (pop) begin
        ctrl_addr  <= head.addr;
        ctrl_wdata <= head.wdata;
      end
      if (last_strobe)
        writes_issued <= writes_issued + CNT_WIDTH'(1);
    end
  end

`ifdef CMS_CTRL_SEQ_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_count <= '0;
    else if (drop_count_clr)
      drop_count <= '0;
    else if (cmd_valid && (!cmd_ready || flush) && (drop_count != '1))
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// Scoreboard bench: default instance for framing/flush/backpressure, a second
// instance (STROBE_CYCLES=3, CNT_WIDTH=4) for async reset and counter wrap.
module tb_cms_ctrl_sequencer;
  import cms_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: defaults
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic        flush = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  ctrl_addr;
  logic [63:0] ctrl_wdata;
  logic        ctrl_write_enable;
  logic        busy;
  logic [3:0]  fifo_level;
  logic [15:0] writes_issued;

  // Instance B: long strobe, narrow counter
  logic        rst_b_n = 1'b0;
  logic        valid_b = 1'b0;
  logic        ready_b;
  logic [7:0]  addr_in_b = '0;
  logic [63:0] wdata_in_b = '0;
  logic        flush_b = 1'b0;
  logic        run_b = 1'b0;
  logic [7:0]  addr_b;
  logic [63:0] wdata_b;
  logic        en_b;
  logic        busy_b;
  logic [3:0]  level_b;
  logic [3:0]  writes_b;

`ifdef CMS_CTRL_SEQ_DROP_CNT_EN
  logic        drop_count_clr = 1'b0;
  logic [15:0] drop_count;
  logic        drop_clr_b = 1'b0;
  logic [15:0] drop_b;
`endif

  cms_ctrl_sequencer u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .flush             (flush),
    .run               (run),
    .ctrl_addr         (ctrl_addr),
    .ctrl_wdata        (ctrl_wdata),
    .ctrl_write_enable (ctrl_write_enable),
    .busy              (busy),
    .fifo_level        (fifo_level),
    .writes_issued     (writes_issued)
`ifdef CMS_CTRL_SEQ_DROP_CNT_EN
    ,
    .drop_count_clr    (drop_count_clr),
    .drop_count        (drop_count)
`endif
  );

  cms_ctrl_sequencer #(
    .STROBE_CYCLES (3),
    .CNT_WIDTH     (4)
  ) u_dut_b (
    .clk               (clk),
    .rst_n             (rst_b_n),
    .cmd_valid         (valid_b),
    .cmd_ready         (ready_b),
    .cmd_addr          (addr_in_b),
    .cmd_wdata         (wdata_in_b),
    .flush             (flush_b),
    .run               (run_b),
    .ctrl_addr         (addr_b),
    .ctrl_wdata        (wdata_b),
    .ctrl_write_enable (en_b),
    .busy              (busy_b),
    .fifo_level        (level_b),
    .writes_issued     (writes_b)
`ifdef CMS_CTRL_SEQ_DROP_CNT_EN
    ,
    .drop_count_clr    (drop_clr_b),
    .drop_count        (drop_b)
`endif
  );

  cms_ctrl_cmd_t sbq[$];
  int  spacing_on = 0;
  int  last_start = -1;
  int  cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor for instance A: checks each strobe against the scoreboard head.
  initial begin
    logic          prev_en;
    int            strobe_len;
    logic [7:0]    setup_addr;
    logic [63:0]   setup_wdata;
    cms_ctrl_cmd_t cur;
    prev_en = 1'b0;
    strobe_len = 0;
    setup_addr = '0;
    setup_wdata = '0;
    cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_en = 1'b0;
        strobe_len = 0;
      end else begin
        if (ctrl_write_enable) begin
          if (!prev_en) begin
            if (sbq.size() == 0) begin
              chk("spurious_strobe", ctrl_write_enable, 1'b0);
            end else begin
              cur = sbq.pop_front();
              chk("strobe_addr", ctrl_addr, cur.addr);
              chk("strobe_wdata", ctrl_wdata, cur.wdata);
              chk("setup_addr", setup_addr, cur.addr);
              chk("setup_wdata", setup_wdata, cur.wdata);
            end
            if (spacing_on != 0 && last_start >= 0)
              chk("strobe_spacing", cyc - last_start, 4);
            last_start = cyc;
            strobe_len = 1;
          end else begin
            strobe_len++;
          end
        end else if (prev_en) begin
          chk("strobe_len", strobe_len, 1);
          chk("gap_addr", ctrl_addr, cur.addr);
          chk("gap_wdata", ctrl_wdata, cur.wdata);
        end
        prev_en = ctrl_write_enable;
        setup_addr = ctrl_addr;
        setup_wdata = ctrl_wdata;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    flush = 1'b0;
    run = 1'b0;
    sbq.delete();
    #5 rst_n = 1'b1;
  endtask

  task automatic do_reset_b();
    @(posedge clk); #1;
    rst_b_n = 1'b0;
    valid_b = 1'b0;
    run_b = 1'b0;
    #5 rst_b_n = 1'b1;
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [63:0] d, input bit accept);
    cmd_addr = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    if (accept) sbq.push_back('{addr: a, wdata: d});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] a, input logic [63:0] d);
    addr_in_b = a;
    wdata_in_b = d;
    valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_idle_b();
    int n;
    n = 0;
    while (busy_b && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_b) chk("idle_timeout_b", busy_b, 1'b0);
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!ctrl_write_enable && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ctrl_write_enable) chk("enable_timeout", ctrl_write_enable, 1'b1);
  endtask

  task automatic wait_en_b();
    int n;
    n = 0;
    while (!en_b && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!en_b) chk("enable_timeout_b", en_b, 1'b1);
  endtask

  initial begin
    cms_ctrl_cmd_t first;

    // Reset values
    do_reset();
    chk("rst_addr", ctrl_addr, 0);
    chk("rst_wdata", ctrl_wdata, 0);
    chk("rst_en", ctrl_write_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_writes", writes_issued, 0);
    chk("rst_ready", cmd_ready, 1);
`ifdef CMS_CTRL_SEQ_DROP_CNT_EN
    chk("rst_drop", drop_count, 0);
`endif

    // Single write latency
    run = 1'b1;
    push_cmd(8'h05, 64'h1, 1'b1);
    chk("single_level", fifo_level, 1);
    @(posedge clk); #1;
    chk("single_addr_e1", ctrl_addr, 8'h05);
    chk("single_wdata_e1", ctrl_wdata, 64'h1);
    chk("single_en_e1", ctrl_write_enable, 0);
    @(posedge clk); #1;
    chk("single_en_e2", ctrl_write_enable, 1);
    @(posedge clk); #1;
    chk("single_en_e3", ctrl_write_enable, 0);
    chk("single_writes", writes_issued, 1);
    chk("single_busy_gap", busy, 1);
    @(posedge clk); #1;
    chk("single_busy_e4", busy, 0);
    chk("single_addr_hold", ctrl_addr, 8'h05);

    // Back-to-back
    do_reset();
    run = 1'b1;
    spacing_on = 1;
    last_start = -1;
    push_cmd(8'h10, 64'hA, 1'b1);
    push_cmd(8'h11, 64'hB, 1'b1);
    push_cmd(8'h12, 64'hC, 1'b1);
    wait_idle();
    spacing_on = 0;
    chk("b2b_writes", writes_issued, 3);
    chk("b2b_sb_empty", sbq.size(), 0);

    // Full / backpressure
    do_reset();
`ifdef CMS_CTRL_SEQ_DROP_CNT_EN
    drop_count_clr = 1'b1;
    @(posedge clk); #1;
    drop_count_clr = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      chk("full_ready_pre", cmd_ready, 1);
      push_cmd(8'h40 + 8'(i), 64'h1000 + 64'(i), 1'b1);
    end
    chk("full_ready_low", cmd_ready, 0);
    chk("full_level", fifo_level, 8);
    cmd_addr = 8'h99;
    cmd_wdata = 64'hDEAD;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("full_level_after_9th", fifo_level, 8);
`ifdef CMS_CTRL_SEQ_DROP_CNT_EN
    chk("drop_count", drop_count, 3);
    drop_count_clr = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    drop_count_clr = 1'b0;
    cmd_valid = 1'b0;
    chk("drop_clr_priority", drop_count, 0);
`endif
    run = 1'b1;
    wait_idle();
    chk("full_writes", writes_issued, 8);
    chk("full_sb_empty", sbq.size(), 0);

    // Flush mid-write
    do_reset();
    for (int i = 0; i < 4; i++)
      push_cmd(8'h20 + 8'(i), 64'h2000 + 64'(i), 1'b1);
    run = 1'b1;
    wait_en();
    flush = 1'b1;
    if (sbq.size() > 0) begin
      first = sbq[0];
      sbq.delete();
      sbq.push_back(first);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_level", fifo_level, 0);
    wait_idle();
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("flush_writes", writes_issued, 1);
    chk("flush_sb_empty", sbq.size(), 0);
    chk("flush_busy", busy, 0);

    // Reset mid-strobe on instance B
    do_reset_b();
    run_b = 1'b1;
    push_b(8'h31, 64'h31);
    push_b(8'h32, 64'h32);
    push_b(8'h33, 64'h33);
    wait_en_b();
    @(posedge clk); #1;
    chk("b_en_2nd_cycle", en_b, 1);
    rst_b_n = 1'b0;
    #1;
    chk("b_rst_en", en_b, 0);
    chk("b_rst_addr", addr_b, 0);
    chk("b_rst_wdata", wdata_b, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_level", level_b, 0);
    chk("b_rst_writes", writes_b, 0);
    chk("b_rst_ready", ready_b, 1);
    #3 rst_b_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b_post_rst_level", level_b, 0);
    chk("b_post_rst_en", en_b, 0);

    // Counter wrap on instance B
    do_reset_b();
    run_b = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_b(8'(i), 64'(i));
      wait_idle_b();
      if (i == 15) chk("b_writes_16", writes_b, 0);
    end
    chk("b_writes_17", writes_b, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
